// File: rtl/pin_pattern_pkg.sv
// pin_pattern_pkg -- shared definitions for the pin pattern generator.
//   MODE_* : pattern-select encodings
//   pp_seed      : seed vector for a mode, bits at or above width forced to 0
//   pp_ca_next   : one rule-30 step on a circular vector of the given width
// The functions work on a PP_MAX_W-bit container; callers use the low
// WIDTH bits, so WIDTH must be below PP_MAX_W.
package pin_pattern_pkg;

  localparam logic [1:0] MODE_CA    = 2'd0;
  localparam logic [1:0] MODE_WALK  = 2'd1;
  localparam logic [1:0] MODE_GRAY  = 2'd2;
  localparam logic [1:0] MODE_CHECK = 2'd3;

  localparam int PP_MAX_W = 256;
  localparam int PP_IDX_W = 8;

  function automatic logic [PP_MAX_W-1:0] pp_seed(input logic [1:0] mode,
                                                  input int unsigned width);
    logic [PP_MAX_W-1:0] s;
    s = '0;
    case (mode)
      MODE_CA, MODE_WALK: s[0] = 1'b1;
      MODE_GRAY:          s = '0;
      default: begin
        for (int i = 0; i < PP_MAX_W; i++) begin
          if ((i < width) && (i[0] == 1'b0)) s[i] = 1'b1;
        end
      end
    endcase
    return s;
  endfunction

  // next[i] = s[i+1] ^ (s[i] | s[i-1]), indices wrap at width
  function automatic logic [PP_MAX_W-1:0] pp_ca_next(input logic [PP_MAX_W-1:0] s,
                                                     input int unsigned width);
    logic [PP_MAX_W-1:0] n;
    logic [PP_IDX_W-1:0] me, up, dn;
    n = '0;
    for (int i = 0; i < PP_MAX_W; i++) begin
      if (i < width) begin
        me   = PP_IDX_W'(i);
        up   = (i + 1 == width) ? '0 : PP_IDX_W'(i + 1);
        dn   = (i == 0) ? PP_IDX_W'(width - 1) : PP_IDX_W'(i - 1);
        n[i] = s[up] ^ (s[me] | s[dn]);
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/pin_pattern_div.sv
// pin_pattern_div -- free-running LOG2DELAY-bit divider producing an
// advance strobe.
//   clk  : system clock
//   rst  : synchronous active-high reset (counter to 0)
//   clr  : synchronous clear (counter to 0)
//   tick : high while the counter holds all ones (once per 2^LOG2DELAY cycles)
module pin_pattern_div
  import pin_pattern_pkg::*;
#(
  parameter int LOG2DELAY = 22
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  logic [LOG2DELAY-1:0] div_q, div_d;

  always_comb begin
    div_d = div_q + 1'b1;
    if (clr) div_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) div_q <= '0;
    else     div_q <= div_d;
  end

  assign tick = &div_q;

endmodule

// File: rtl/pin_pattern_gen.sv
// pin_pattern_gen -- pin-level test pattern generator for board bring-up.
//   pclk  : system clock (single domain; advances use a clock-enable strobe)
//   rst   : synchronous active-high reset
//   mode  : 0 rule-30 CA, 1 walking one, 2 Gray counter, 3 checkerboard
//   run   : 1 = advance on each divider tick, 0 = hold
//   step  : single-cycle pulse, advances once while run = 0
//   mask  : (only with PIN_PATTERN_MASK_EN) per-bit output enable
//   D     : pattern state (masked when PIN_PATTERN_MASK_EN is defined)
//   adv   : pulse in the cycle D takes a new value
//   wrap  : pulse with adv when the pattern returns to its seed
// Build option: define PIN_PATTERN_MASK_EN to add the mask input.
module pin_pattern_gen
  import pin_pattern_pkg::*;
#(
  parameter int WIDTH     = 110,
  parameter int LOG2DELAY = 22
) (
  input  logic             pclk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             run,
  input  logic             step,
`ifdef PIN_PATTERN_MASK_EN
  input  logic [WIDTH-1:0] mask,
`endif
  output logic [WIDTH-1:0] D,
  output logic             adv,
  output logic             wrap
);

  logic [WIDTH-1:0]    st_q, st_d;
  logic [WIDTH-1:0]    cnt_q, cnt_d;
  logic [1:0]          mode_q, mode_d;
  logic                adv_q, adv_d;
  logic                wrap_q, wrap_d;
  logic                tick, mode_chg, adv_next;
  logic [PP_MAX_W-1:0] seed_full, ca_in, ca_full;
  logic [WIDTH-1:0]    seed_w, ca_w;
  logic                unused_hi;

  assign mode_chg = (mode != mode_q);
  assign adv_next = (run & tick) | (~run & step);

  pin_pattern_div #(
    .LOG2DELAY(LOG2DELAY)
  ) u_div (
    .clk (pclk),
    .rst (rst),
    .clr (mode_chg),
    .tick(tick)
  );

  always_comb begin
    seed_full = pp_seed(mode, WIDTH);
    ca_in     = '0;
    ca_in[WIDTH-1:0] = st_q;
    ca_full   = pp_ca_next(ca_in, WIDTH);
    seed_w    = seed_full[WIDTH-1:0];
    ca_w      = ca_full[WIDTH-1:0];
  end

  assign unused_hi = ^{seed_full[PP_MAX_W-1:WIDTH], ca_full[PP_MAX_W-1:WIDTH]};

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    mode_d = mode;
    adv_d  = 1'b0;
    wrap_d = 1'b0;
    if (mode_chg) begin
      // New mode restarts from its seed; any coincident advance is dropped.
      st_d  = seed_w;
      cnt_d = '0;
    end else if (adv_next) begin
      adv_d = 1'b1;
      case (mode_q)
        MODE_CA: begin
          // All-zero is a fixed point of rule 30, so reseed instead.
          st_d = (ca_w == '0) ? seed_w : ca_w;
        end
        MODE_WALK: begin
          st_d   = {st_q[WIDTH-2:0], st_q[WIDTH-1]};
          wrap_d = st_q[WIDTH-1];
        end
        MODE_GRAY: begin
          cnt_d  = cnt_q + 1'b1;
          st_d   = cnt_d ^ (cnt_d >> 1);
          wrap_d = &cnt_q;
        end
        default: begin
          st_d   = ~st_q;
          wrap_d = (~st_q == seed_w);
        end
      endcase
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      st_q   <= seed_w;
      cnt_q  <= '0;
      mode_q <= mode;
      adv_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      mode_q <= mode_d;
      adv_q  <= adv_d;
      wrap_q <= wrap_d;
    end
  end

`ifdef PIN_PATTERN_MASK_EN
  logic [WIDTH-1:0] mask_q, mask_d;

  // Mask is registered alongside the state so both change on the same edge.
  always_comb mask_d = mask;

  always_ff @(posedge pclk) mask_q <= mask_d;

  assign D = st_q & mask_q;
`else
  assign D = st_q;
`endif

  assign adv  = adv_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_pin_pattern_gen.sv
// tb_pin_pattern_gen -- randomized and directed bench for pin_pattern_gen
// (WIDTH=8, LOG2DELAY=2) against a behavioural model that tracks the
// pattern as a position / phase / counter rather than as bit registers.
module tb_pin_pattern_gen;

  localparam int W = 8;

  logic         pclk = 1'b0;
  logic         rst  = 1'b1;
  logic [1:0]   mode = 2'd0;
  logic         run  = 1'b0;
  logic         step = 1'b0;
  logic [W-1:0] mask = '1;
  logic [W-1:0] D;
  logic         adv, wrap;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model state
  int       m_mode, m_div, m_pos, m_cnt, m_ph;
  logic [7:0] m_ca;
  logic [7:0] e_d;
  logic       e_adv, e_wrap;

  always #5 pclk = ~pclk;

  pin_pattern_gen #(.WIDTH(W), .LOG2DELAY(2)) dut (
    .pclk(pclk),
    .rst (rst),
    .mode(mode),
    .run (run),
    .step(step),
`ifdef PIN_PATTERN_MASK_EN
    .mask(mask),
`endif
    .D   (D),
    .adv (adv),
    .wrap(wrap)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ca_rule(input logic [7:0] s);
    logic [7:0] n;
    for (int i = 0; i < 8; i++)
      n[i] = s[(i + 1) % 8] ^ (s[i] | s[(i + 7) % 8]);
    return (n == 8'h00) ? 8'h01 : n;
  endfunction

  function automatic logic [7:0] model_pattern();
    case (m_mode)
      0:       return m_ca;
      1:       return 8'(1 << m_pos);
      2:       return 8'(m_cnt ^ (m_cnt >> 1));
      default: return (m_ph != 0) ? 8'hAA : 8'h55;
    endcase
  endfunction

  task automatic model_seed(input int md);
    m_mode = md;
    m_div  = 0;
    m_pos  = 0;
    m_cnt  = 0;
    m_ph   = 0;
    m_ca   = 8'h01;
  endtask

  // Effect of one rising edge given the inputs present before it.
  task automatic model_edge();
    bit tk, go;
    e_adv  = 1'b0;
    e_wrap = 1'b0;
    if (rst) begin
      model_seed(int'(mode));
    end else if (int'(mode) != m_mode) begin
      model_seed(int'(mode));
    end else begin
      tk    = (m_div == 3);
      m_div = (m_div + 1) % 4;
      go    = run ? tk : step;
      if (go) begin
        e_adv = 1'b1;
        case (m_mode)
          0: m_ca = ca_rule(m_ca);
          1: begin e_wrap = (m_pos == 7); m_pos = (m_pos + 1) % 8; end
          2: begin m_cnt = (m_cnt + 1) % 256; e_wrap = (m_cnt == 0); end
          default: begin m_ph = 1 - m_ph; e_wrap = (m_ph == 0); end
        endcase
      end
    end
    e_d = model_pattern() & mask;
  endtask

  // Apply inputs, clock once, update the model, then check at the falling edge.
  task automatic cyc(input logic r, input logic [1:0] md, input logic rn, input logic st);
    rst  = r;
    mode = md;
    run  = rn;
    step = st;
    @(posedge pclk);
    model_edge();
    @(negedge pclk);
    check_val("D", 32'(D), 32'(e_d));
    check_val("adv", 32'(adv), 32'(e_adv));
    check_val("wrap", 32'(wrap), 32'(e_wrap));
  endtask

  initial begin
    int guard;
    logic rr, rn, st;
    logic [1:0] md;
    model_seed(0);
    @(negedge pclk);

    // 1: CA from reset
    cyc(1'b1, 2'd0, 1'b0, 1'b0);
    check_val("ca_rst_D", 32'(D), 32'h01);
    for (int k = 0; k < 4; k++) cyc(1'b0, 2'd0, 1'b1, 1'b0);
    check_val("ca_first_D", 32'(D), 32'h83);
    check_val("ca_first_adv", 32'(adv), 32'h1);
    for (int k = 0; k < 24; k++) cyc(1'b0, 2'd0, 1'b1, 1'b0);

    // 2: walking one, full lap plus a bit
    for (int k = 0; k < 40; k++) cyc(1'b0, 2'd1, 1'b1, 1'b0);

    // 3: Gray counter through its full period
    for (int k = 0; k < 256 * 4 + 8; k++) cyc(1'b0, 2'd2, 1'b1, 1'b0);

    // 4: checkerboard single-step
    cyc(1'b0, 2'd3, 1'b0, 1'b0);
    check_val("chk_seed", 32'(D), 32'h55);
    for (int p = 0; p < 3; p++) begin
      cyc(1'b0, 2'd3, 1'b0, 1'b1);
      for (int k = 0; k < 9; k++) cyc(1'b0, 2'd3, 1'b0, 1'b0);
    end
    check_val("chk_after3", 32'(D), 32'hAA);

    // 5: walk -> checker switch while D = 10
    cyc(1'b1, 2'd1, 1'b1, 1'b0);
    guard = 0;
    while (D !== 8'h10 && guard < 100) begin
      cyc(1'b0, 2'd1, 1'b1, 1'b0);
      guard++;
    end
    check_val("sw_reach10", 32'(D), 32'h10);
    cyc(1'b0, 2'd3, 1'b1, 1'b0);
    check_val("sw_D", 32'(D), 32'h55);
    check_val("sw_adv", 32'(adv), 32'h0);
    for (int k = 0; k < 4; k++) cyc(1'b0, 2'd3, 1'b1, 1'b0);
    check_val("sw_next", 32'(D), 32'hAA);

    // 6: reset mid-sequence with coincident step
    for (int k = 0; k < 13; k++) cyc(1'b0, 2'd1, 1'b1, 1'b0);
    cyc(1'b1, 2'd1, 1'b1, 1'b1);
    check_val("rst_mid_D", 32'(D), 32'h01);
    check_val("rst_mid_adv", 32'(adv), 32'h0);
    check_val("rst_mid_wrap", 32'(wrap), 32'h0);
`ifdef PIN_PATTERN_MASK_EN
    mask = 8'h0F;
    cyc(1'b1, 2'd3, 1'b1, 1'b0);
    check_val("mask_rst", 32'(D), 32'h05);
    for (int k = 0; k < 4; k++) cyc(1'b0, 2'd3, 1'b1, 1'b0);
    check_val("mask_adv", 32'(D), 32'h0A);
    mask = '1;
`endif

    // randomized traffic
    md = 2'd0;
    rn = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      rr = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 49) == 0) md = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) rn = ~rn;
      st = ($urandom_range(0, 4) == 0);
`ifdef PIN_PATTERN_MASK_EN
      if ($urandom_range(0, 19) == 0) mask = 8'($urandom);
`endif
      cyc(rr, md, rn, st);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pin_pattern_gen.md
Name: pin_pattern_gen

Overview:
Parametrised pin-level test pattern generator for board bring-up. It drives a WIDTH-bit output bus with one of four selectable patterns, advancing at a programmable divided rate or by single-step. It replaces ad-hoc divided-clock generators: the design has one clock domain and advances on a clock-enable strobe. It sits directly behind the top-level output pins.

Parameters:
WIDTH, 110, output bus width (>= 4)
LOG2DELAY, 22, divider width; free-run advance period = 2^LOG2DELAY pclk cycles (>= 1)

Ports:
pclk  input  1  system clock
rst  input  1  synchronous reset, active-high
mode  input  2  pattern select: 0 CA (rule 30), 1 walking-one, 2 Gray counter, 3 checkerboard
run  input  1  1 = advance on every divider tick; 0 = hold
step  input  1  single-cycle pulse; advances once when run=0
D  output  WIDTH  pattern state
adv  output  1  one-cycle pulse, high in the cycle D takes a new value
wrap  output  1  one-cycle pulse, coincident with adv, when the pattern returns to its seed

Behaviour:
- Divider: LOG2DELAY-bit counter div, +1 every cycle, wrapping. tick = (div == all ones). The counter resets to 0 on rst and on any mode change.
- Advance condition (registered): adv_next = (run & tick) | (~run & step). step is ignored while run=1.
- Seeds: CA = 1 in bit 0 only; walk = 1 in bit 0 only; Gray = all zero (internal binary counter cnt = 0); checker = bit i equal to ~i[0] (0x...55).
- Next state per mode, with index arithmetic mod WIDTH:
  - CA: next[i] = s[i+1] ^ (s[i] | s[i-1]), circular.
  - Walk: rotate left by 1.
  - Gray: cnt <= cnt + 1 (WIDTH bits, wraps); D = cnt ^ (cnt >> 1).
  - Checker: D <= ~D.
- Latency: D updates on the pclk edge after adv_next is evaluated. adv and wrap are asserted in the same cycle that the new D is visible.
- wrap conditions:
  - walk: bit WIDTH-1 rotates into bit 0.
  - Gray: cnt wraps from all ones to 0.
  - checker: D returns to the seed (every 2nd advance).
  - CA: wrap is never asserted.
- CA lock-up guard: if the CA next state would be all zero, the seed is loaded instead. adv still pulses; wrap stays 0.
- Mode change: mode_q registers mode. When mode != mode_q:
  - the next cycle loads the new mode's seed and clears div;
  - adv and wrap stay 0 for that cycle;
  - a coincident advance is discarded.
- Reset: all outputs take their reset values the cycle after rst=1.
  - D = seed of the current mode input; cnt = 0; div = 0; mode_q = mode.
  - adv = 0; wrap = 0.
  - rst has priority over mode change, step and tick. Asserting rst mid-pattern aborts the pattern immediately.

Optional Feature:
PIN_PATTERN_MASK_EN:
- Defined: adds input port mask (WIDTH bits). The registered output becomes D = state & mask, with mask registered so D keeps 1-cycle alignment. Masked bits drive 0. Internal state is unaffected, so unmasking resumes the true sequence.
- Undefined: no mask port; D = state.

Decomposition:
- Package pin_pattern_pkg holds:
  - mode localparams MODE_CA=2'd0, MODE_WALK=2'd1, MODE_GRAY=2'd2, MODE_CHECK=2'd3;
  - a seed function (mode, WIDTH) and a next-state function for the CA.
- Sub-module pin_pattern_div: LOG2DELAY counter with synchronous clear, producing tick.

Test Plan:
All scenarios use WIDTH=8 and LOG2DELAY=2 (a tick every 4 cycles).
1. rst with mode=0, then run=1 -> D=8'h01 after reset; after the first adv D=8'h83; adv pulses exactly every 4 cycles; wrap stays 0.
2. mode=1, run=1 -> D = 01, 02, 04, ..., 80, 01; wrap is high only on the 80->01 advance.
3. mode=2, run=1 -> D = 00, 01, 03, 02, 06, 07, 05, 04, ...; after 256 advances D=00 with wrap=1.
4. mode=3, run=0, three step pulses spaced 10 cycles apart -> D = 55, AA, 55, AA; exactly three adv pulses; wrap on the 2nd step; no change between steps even across ticks.
5. mode 1->3 switch while D=8'h10 and run=1 -> the next cycle shows D=8'h55, div cleared, adv=0; the next advance comes 4 cycles later with D=AA.
6. rst asserted for 1 cycle mid-sequence in mode 1 with step=1 coincident -> D=8'h01, adv=0, wrap=0; with PIN_PATTERN_MASK_EN defined and mask=8'h0F in mode 3, D alternates 05/0A.
